// File: rtl/fifo_burst_reader.sv
// Pop-side burst controller for the synchronous FIFO.
// Tracks one-cycle pop latency and holds returned words in a 2-entry skid buffer.
module fifo_burst_reader #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic             fifo_empty_i,
  output logic             fifo_pop_o,
  input  logic [WIDTH-1:0] fifo_data_i,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [LEN_W-1:0] count_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued;
  logic [LEN_W-1:0] count;
  logic [WIDTH-1:0] sb0;
  logic [WIDTH-1:0] sb1;
  logic [1:0]       occ;
  logic             infl;
  logic             run;
  logic             xfer;
  logic             accept;
  logic             last;
  logic [2:0]       level;

  assign run    = (state == S_RUN);
  assign xfer   = m_valid_o && m_ready_i;
  assign accept = (state == S_IDLE) && start_i;
  assign last   = (count == len_q - LEN_W'(1));

  // Projected fill after this cycle; in-flight word already owns a slot.
  assign level = {1'b0, occ} + {2'b00, infl} - {2'b00, xfer};

  assign fifo_pop_o = run && !fifo_empty_i &&
                      (issued < len_q) && (level < 3'd2);

  assign m_valid_o = (occ != 2'd0);
  assign m_data_o  = sb0;
  assign busy_o    = run;
  assign done_o    = (state == S_DONE);
  assign count_o   = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (start_i)
                  state <= (len_i == '0) ? S_DONE : S_RUN;
        S_RUN:  if (xfer && last) state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      issued <= '0;
      count  <= '0;
      infl   <= 1'b0;
    end else begin
      infl <= fifo_pop_o;
      if (accept) begin
        len_q  <= len_i;
        issued <= '0;
        count  <= '0;
      end else begin
        if (fifo_pop_o) issued <= issued + LEN_W'(1);
        if (xfer)       count  <= count + LEN_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb0 <= '0;
      sb1 <= '0;
      occ <= 2'd0;
    end else begin
      unique case ({infl, xfer})
        2'b10: begin
          if (occ == 2'd0) sb0 <= fifo_data_i;
          else             sb1 <= fifo_data_i;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          sb0 <= sb1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            sb0 <= fifo_data_i;
          end else begin
            sb0 <= sb1;
            sb1 <= fifo_data_i;
          end
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
      ({1'b0, occ} + {2'b00, infl}) <= 3'd2
  );

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: behavioural FIFO, vector table,
// output scoreboard and hand-written corner sequences.
module tb_fifo_burst_reader;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [7:0]  len_i;
  logic        fifo_empty;
  logic        fifo_pop_o;
  logic [15:0] fifo_data;
  logic        m_valid_o;
  logic [15:0] m_data_o;
  logic        m_ready_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  count_o;

  fifo_burst_reader #(.WIDTH(16), .LEN_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start_i),
    .len_i        (len_i),
    .fifo_empty_i (fifo_empty),
    .fifo_pop_o   (fifo_pop_o),
    .fifo_data_i  (fifo_data),
    .m_valid_o    (m_valid_o),
    .m_data_o     (m_data_o),
    .m_ready_i    (m_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .count_o      (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural FIFO: data returned one cycle after pop.
  logic [15:0] fmem [0:255];
  int rd = 0;
  int wr = 0;
  assign fifo_empty = (rd == wr);
  always @(posedge clk) begin
    if (fifo_pop_o && rd != wr) begin
      fifo_data <= fmem[rd & 255];
      rd        <= rd + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  int pop_cnt, nxfer, done_cnt;
  int first_pop, last_pop, first_x, last_x, st_cyc;
  logic prev_v, prev_r;
  logic [15:0] prev_d;

  initial begin
    done_cnt = 0;
    pop_cnt = 0;
    nxfer = 0;
    prev_v = 0;
    prev_r = 0;
    prev_d = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v = 1'b0;
    end else begin
      if (fifo_pop_o) begin
        pop_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        checks++;
        if (fifo_empty || !busy_o) begin
          errors++;
          $display("FAIL pop_guard empty=%0b busy=%0b required pop=0",
                   fifo_empty, busy_o);
        end
      end
      if (prev_v && !prev_r) begin
        checks++;
        if (!m_valid_o || m_data_o != prev_d) begin
          errors++;
          $display("FAIL stall_hold actual v=%0b d=%h required v=1 d=%h",
                   m_valid_o, m_data_o, prev_d);
        end
      end
      if (m_valid_o && m_ready_i) begin
        logic [15:0] e;
        nxfer++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra actual=%h required=none", m_data_o);
        end else begin
          e = exp_q.pop_front();
          if (m_data_o !== e) begin
            errors++;
            $display("FAIL sb_data actual=%h required=%h", m_data_o, e);
          end
        end
      end
      if (done_o) done_cnt++;
      prev_v = m_valid_o;
      prev_r = m_ready_i;
      prev_d = m_data_o;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push_words(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      fmem[wr & 255] = base + 16'(i);
      exp_q.push_back(base + 16'(i));
      wr = wr + 1;
    end
  endtask

  task automatic clear_stats();
    pop_cnt = 0;
    nxfer = 0;
    first_pop = -1;
    last_pop = -1;
    first_x = -1;
    last_x = -1;
  endtask

  task automatic start_burst(input int len);
    start_i = 1'b1;
    len_i = 8'(len);
    st_cyc = cyc;
    tick();
    start_i = 1'b0;
    len_i = 8'd0;
  endtask

  task automatic wait_done(input int budget, input int rper);
    bit seen;
    seen = 0;
    for (int k = 0; k < budget; k++) begin
      if (done_o) begin
        seen = 1;
        break;
      end
      m_ready_i = ((k % rper) == 0);
      tick();
    end
    chk("done_timeout", int'(seen), 1);
    m_ready_i = 1'b1;
  endtask

  typedef struct {
    int          len;
    logic [15:0] base;
    int          rper;
    int          exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int d0;
    vecs[0] = '{len: 4, base: 16'h0001, rper: 1, exp_cnt: 4};
    vecs[1] = '{len: 6, base: 16'h0100, rper: 3, exp_cnt: 6};
    vecs[2] = '{len: 1, base: 16'h0200, rper: 1, exp_cnt: 1};
    vecs[3] = '{len: 2, base: 16'h0300, rper: 2, exp_cnt: 2};
    vecs[4] = '{len: 0, base: 16'h0000, rper: 1, exp_cnt: 0};

    rst_n = 1'b0;
    start_i = 1'b0;
    len_i = 8'd0;
    m_ready_i = 1'b1;
    clear_stats();
    tick();
    tick();
    chk("rst_valid", int'(m_valid_o), 0);
    chk("rst_data", int'(m_data_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_count", int'(count_o), 0);
    chk("rst_pop", int'(fifo_pop_o), 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      clear_stats();
      push_words(vecs[i].len, vecs[i].base);
      d0 = done_cnt;
      m_ready_i = 1'b1;
      start_burst(vecs[i].len);
      wait_done(200, vecs[i].rper);
      tick();
      chk($sformatf("v%0d_count", i), int'(count_o), vecs[i].exp_cnt);
      chk($sformatf("v%0d_pops", i), pop_cnt, vecs[i].exp_cnt);
      chk($sformatf("v%0d_done", i), done_cnt - d0, 1);
      chk($sformatf("v%0d_left", i), exp_q.size(), 0);
      chk($sformatf("v%0d_busy", i), int'(busy_o), 0);
      if (i == 0) begin
        chk("thr_first_pop", first_pop - st_cyc, 1);
        chk("thr_pop_span", last_pop - first_pop, 3);
        chk("thr_latency", first_x - first_pop, 2);
        chk("thr_xfer_span", last_x - first_x, 3);
      end
    end

    // Zero-length burst: done on the cycle after start, no pops.
    clear_stats();
    d0 = done_cnt;
    start_burst(0);
    chk("z_done_hi", int'(done_o), 1);
    chk("z_pop", int'(fifo_pop_o), 0);
    chk("z_count", int'(count_o), 0);
    tick();
    chk("z_done_lo", int'(done_o), 0);
    chk("z_pulses", done_cnt - d0, 1);

    // Empty FIFO for five cycles, then words arrive.
    clear_stats();
    m_ready_i = 1'b1;
    start_burst(3);
    for (int k = 0; k < 5; k++) begin
      chk("e_no_pop", int'(fifo_pop_o), 0);
      tick();
    end
    push_words(3, 16'h000A);
    wait_done(100, 1);
    tick();
    chk("e_count", int'(count_o), 3);
    chk("e_left", exp_q.size(), 0);

    // Reset in the middle of a burst: 2 delivered, 2 buffered.
    clear_stats();
    push_words(5, 16'h0500);
    m_ready_i = 1'b1;
    start_burst(5);
    for (int k = 0; k < 50; k++) begin
      if (nxfer >= 2) break;
      tick();
    end
    m_ready_i = 1'b0;
    tick();
    tick();
    tick();
    tick();
    chk("r_delivered", nxfer, 2);
    chk("r_pops", pop_cnt, 4);
    chk("r_valid", int'(m_valid_o), 1);
    chk("r_head", int'(m_data_o), 16'h0502);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("r_valid0", int'(m_valid_o), 0);
    chk("r_data0", int'(m_data_o), 0);
    chk("r_busy0", int'(busy_o), 0);
    chk("r_count0", int'(count_o), 0);
    chk("r_pop0", int'(fifo_pop_o), 0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    wr = rd;
    m_ready_i = 1'b1;
    tick();
    tick();
    chk("r_no_done", done_cnt - d0, 0);
    clear_stats();
    push_words(1, 16'h0055);
    start_burst(1);
    wait_done(100, 1);
    tick();
    chk("r_new_count", int'(count_o), 1);
    chk("r_new_left", exp_q.size(), 0);

    // Start re-asserted during RUN must be ignored.
    clear_stats();
    push_words(4, 16'h0400);
    d0 = done_cnt;
    m_ready_i = 1'b1;
    start_burst(4);
    m_ready_i = 1'b0;
    tick();
    start_i = 1'b1;
    len_i = 8'd9;
    tick();
    start_i = 1'b0;
    len_i = 8'd0;
    wait_done(200, 2);
    tick();
    chk("i_count", int'(count_o), 4);
    chk("i_pops", pop_cnt, 4);
    chk("i_done", done_cnt - d0, 1);
    chk("i_left", exp_q.size(), 0);
    tick();
    chk("i_hold", int'(count_o), 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
